// File: rtl/approx_vedic_mult_8x8.sv
// Two-stage 8x8 Urdhva-Tiryagbhyam multiplier with exact and approximate products.
// The low 4x4 block of the approximate path uses 2x2 cells that map 3x3 to 7.
module approx_vedic_mult_8x8 #(
  parameter int APPROX_EN = 1,
  parameter int CNT_W     = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             clr_stats,
  output logic             out_valid,
  output logic [15:0]      p_exact,
  output logic [15:0]      p_approx,
  output logic [15:0]      err,
  output logic [15:0]      err_max,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic APX = (APPROX_EN != 0);

  function automatic logic [3:0] cell2(
    input logic [1:0] x,
    input logic [1:0] y,
    input logic       apx
  );
    logic [3:0] p;
    p = {2'b00, x} * {2'b00, y};
    if (apx && (x == 2'd3) && (y == 2'd3))
      p = 4'd7;
    return p;
  endfunction

  function automatic logic [7:0] blk4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       apx
  );
    logic [7:0] hh, hl, lh, ll;
    hh = {4'h0, cell2(x[3:2], y[3:2], apx)};
    hl = {4'h0, cell2(x[3:2], y[1:0], apx)};
    lh = {4'h0, cell2(x[1:0], y[3:2], apx)};
    ll = {4'h0, cell2(x[1:0], y[1:0], apx)};
    return (hh << 4) + ((hl + lh) << 2) + ll;
  endfunction

  logic       s1_v;
  logic [7:0] s1_hh, s1_hl, s1_lh, s1_ll, s1_lla;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_hh  <= '0;
      s1_hl  <= '0;
      s1_lh  <= '0;
      s1_ll  <= '0;
      s1_lla <= '0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_hh  <= blk4(a[7:4], b[7:4], 1'b0);
        s1_hl  <= blk4(a[7:4], b[3:0], 1'b0);
        s1_lh  <= blk4(a[3:0], b[7:4], 1'b0);
        s1_ll  <= blk4(a[3:0], b[3:0], 1'b0);
        s1_lla <= blk4(a[3:0], b[3:0], APX);
      end
    end
  end

  logic [15:0] mid_n, ex_n, ap_n, err_n;

  assign mid_n = (16'(s1_hl) + 16'(s1_lh)) << 4;
  assign ex_n  = {s1_hh, 8'h00} + mid_n + 16'(s1_ll);
  assign ap_n  = {s1_hh, 8'h00} + mid_n + 16'(s1_lla);
  // approx low block never exceeds exact, so no sign handling
  assign err_n = ex_n - ap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      p_exact   <= '0;
      p_approx  <= '0;
      err       <= '0;
    end else begin
      out_valid <= s1_v;
      if (s1_v) begin
        p_exact  <= ex_n;
        p_approx <= ap_n;
        err      <= err_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_max <= '0;
      err_cnt <= '0;
    end else if (clr_stats) begin
      err_max <= '0;
      err_cnt <= '0;
    end else if (s1_v) begin
      if (err_n > err_max)
        err_max <= err_n;
      if ((err_n != 16'd0) && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_approx_vedic_mult_8x8.sv
// Randomised and swept check of approx_vedic_mult_8x8 against an arithmetic model.
// Runs an approximate and an exact instance side by side on the same inputs.
module tb_approx_vedic_mult_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        clr_stats = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;

  logic        ov1, ov0;
  logic [15:0] pe1, pa1, er1, em1;
  logic [15:0] pe0, pa0, er0, em0;
  logic [16:0] ec1, ec0;

  int n_vec = 0;
  int n_bad = 0;

  approx_vedic_mult_8x8 #(.APPROX_EN(1), .CNT_W(17)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .clr_stats(clr_stats), .out_valid(ov1), .p_exact(pe1),
    .p_approx(pa1), .err(er1), .err_max(em1), .err_cnt(ec1)
  );

  approx_vedic_mult_8x8 #(.APPROX_EN(0), .CNT_W(17)) u_ex (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .clr_stats(clr_stats), .out_valid(ov0), .p_exact(pe0),
    .p_approx(pa0), .err(er0), .err_max(em0), .err_cnt(ec0)
  );

  always #5 clk = ~clk;

  // Error of the approximate product: every 2x2 digit pair of the
  // low nibbles that is 3x3 loses 2 at its weight.
  function automatic int ref_err(input int x, input int y);
    int lx, ly, dx, dy, e;
    lx = x % 16;
    ly = y % 16;
    e  = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        dx = (lx >> (2 * i)) % 4;
        dy = (ly >> (2 * j)) % 4;
        if (dx == 3 && dy == 3)
          e += 2 << (2 * (i + j));
      end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y);
    in_valid = v;
    a = x;
    b = y;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 8'd0, 8'd0);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    n_vec++;
    if ({ov1, pe1, pa1, er1} !== 49'd0) begin
      n_bad++;
      $display("FAIL reset_out got v=%b pe=%0d pa=%0d e=%0d need all 0",
               ov1, pe1, pa1, er1);
    end
    n_vec++;
    if ({em1, ec1} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset_stats got max=%0d cnt=%0d need 0", em1, ec1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_directed;
    int da[5] = '{3, 255, 16, 2, 0};
    int db[5] = '{3, 255, 16, 3, 200};
    logic [15:0] xe, xa, xr;
    for (int k = 0; k < 5; k++) begin
      xe = 16'(da[k] * db[k]);
      xr = 16'(ref_err(da[k], db[k]));
      xa = xe - xr;
      @(negedge clk);
      drive(1'b1, 8'(da[k]), 8'(db[k]));
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0);
      n_vec++;
      if (ov1 !== 1'b0) begin
        n_bad++;
        $display("FAIL latency_early k=%0d out_valid=%b need 0", k, ov1);
      end
      @(negedge clk);
      n_vec++;
      if (ov1 !== 1'b1 || pe1 !== xe || pa1 !== xa || er1 !== xr) begin
        n_bad++;
        $display("FAIL directed %0dx%0d got v=%b %0d/%0d/%0d need 1 %0d/%0d/%0d",
                 da[k], db[k], ov1, pe1, pa1, er1, xe, xa, xr);
      end
      @(negedge clk);
      n_vec++;
      if (ov1 !== 1'b0 || pe1 !== xe || er1 !== xr) begin
        n_bad++;
        $display("FAIL hold %0dx%0d got v=%b pe=%0d e=%0d need 0 %0d %0d",
                 da[k], db[k], ov1, pe1, er1, xe, xr);
      end
    end
    idle(2);
  endtask

  task automatic test_clear_priority;
    drive(1'b1, 8'd255, 8'd255);
    @(negedge clk);
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    n_vec++;
    if (em1 !== 16'd0 || ec1 !== 17'd0) begin
      n_bad++;
      $display("FAIL clr_priority got max=%0d cnt=%0d need 0 0", em1, ec1);
    end
    @(negedge clk);
    n_vec++;
    if (em1 !== 16'd50 || ec1 !== 17'd1) begin
      n_bad++;
      $display("FAIL clr_resume got max=%0d cnt=%0d need 50 1", em1, ec1);
    end
    idle(3);
  endtask

  task automatic test_random;
    logic hv[2];
    int ha[2], hb[2];
    int exp_max, exp_cnt, x, y, e;
    logic have;
    logic [15:0] le, lr;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    exp_max = 0;
    exp_cnt = 0;
    have = 1'b0;
    le = '0;
    lr = '0;
    hv = '{1'b0, 1'b0};
    ha = '{0, 0};
    hb = '{0, 0};
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (hv[1]) begin
        e = ref_err(ha[1], hb[1]);
        le = 16'(ha[1] * hb[1]);
        lr = 16'(e);
        have = 1'b1;
        if (e > exp_max) exp_max = e;
        if (e != 0) exp_cnt++;
      end
      n_vec++;
      if (ov1 !== hv[1] ||
          (have && (pe1 !== le || pa1 !== le - lr || er1 !== lr))) begin
        n_bad++;
        $display("FAIL random n=%0d got v=%b %0d/%0d/%0d need v=%b %0d/%0d/%0d",
                 n, ov1, pe1, pa1, er1, hv[1], le, le - lr, lr);
      end
      n_vec++;
      if (em1 !== 16'(exp_max) || ec1 !== 17'(exp_cnt)) begin
        n_bad++;
        $display("FAIL random_stats n=%0d got max=%0d cnt=%0d need %0d %0d",
                 n, em1, ec1, exp_max, exp_cnt);
      end
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      hv[1] = hv[0];
      ha[1] = ha[0];
      hb[1] = hb[0];
      hv[0] = ($urandom_range(0, 3) != 0);
      ha[0] = x;
      hb[0] = y;
      drive(hv[0], 8'(x), 8'(y));
    end
    idle(3);
  endtask

  task automatic test_reset_flush;
    @(negedge clk);
    drive(1'b1, 8'd3, 8'd3);
    @(negedge clk);
    drive(1'b1, 8'd255, 8'd255);
    #1 rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (ov1 !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_in_reset i=%0d out_valid=%b need 0", i, ov1);
      end
    end
    n_vec++;
    if (em1 !== 16'd0 || ec1 !== 17'd0 || pe1 !== 16'd0) begin
      n_bad++;
      $display("FAIL flush_state got max=%0d cnt=%0d pe=%0d need 0", em1, ec1, pe1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (ov1 !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_after i=%0d out_valid=%b need 0", i, ov1);
      end
    end
  endtask

  task automatic test_sweep;
    logic hv[2];
    int ha[2], hb[2];
    int cnt_ref, max_ref, e, p;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    cnt_ref = 0;
    max_ref = 0;
    hv = '{1'b0, 1'b0};
    ha = '{0, 0};
    hb = '{0, 0};
    for (int n = 0; n < 65538; n++) begin
      @(negedge clk);
      if (hv[1]) begin
        e = ref_err(ha[1], hb[1]);
        p = ha[1] * hb[1];
        if (e != 0) cnt_ref++;
        if (e > max_ref) max_ref = e;
        n_vec++;
        if (ov1 !== 1'b1 || pe1 !== 16'(p) ||
            pa1 !== 16'(p - e) || er1 !== 16'(e)) begin
          n_bad++;
          $display("FAIL sweep %0dx%0d got v=%b %0d/%0d/%0d need 1 %0d/%0d/%0d",
                   ha[1], hb[1], ov1, pe1, pa1, er1, p, p - e, e);
        end
        n_vec++;
        if (ov0 !== 1'b1 || pe0 !== 16'(p) ||
            pa0 !== 16'(p) || er0 !== 16'd0) begin
          n_bad++;
          $display("FAIL sweep_exact %0dx%0d got v=%b %0d/%0d/%0d need 1 %0d/%0d/0",
                   ha[1], hb[1], ov0, pe0, pa0, er0, p, p);
        end
      end
      hv[1] = hv[0];
      ha[1] = ha[0];
      hb[1] = hb[0];
      hv[0] = (n < 65536);
      ha[0] = n / 256;
      hb[0] = n % 256;
      drive(hv[0], 8'(ha[0]), 8'(hb[0]));
    end
    idle(2);
    n_vec++;
    if (em1 !== 16'(max_ref) || max_ref != 50 || ec1 !== 17'(cnt_ref)) begin
      n_bad++;
      $display("FAIL sweep_stats got max=%0d cnt=%0d need 50 %0d", em1, ec1, cnt_ref);
    end
    n_vec++;
    if (em0 !== 16'd0 || ec0 !== 17'd0) begin
      n_bad++;
      $display("FAIL sweep_exact_stats got max=%0d cnt=%0d need 0 0", em0, ec0);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_clear_priority;
    test_random;
    test_reset_flush;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
